// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the write port of a single FIFO among NUM_REQ producers. Arbitration
// is round-robin with a bounded burst lock: once granted, a producer may keep
// the port for up to MAX_BURST consecutive accepted beats. After that, the
// search rotates to the next requester. The grant is purely combinational, so
// a beat is accepted in the same cycle that the producer presents it.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   req_valid     per-producer data valid            [NUM_REQ]
//   req_data      producer i data at [i*WIDTH +: WIDTH]
//   req_ready     per-producer accept (one-hot or zero)
//   fifo_full     FIFO full flag
//   fifo_write    FIFO write strobe
//   fifo_data_in  FIFO write data (zero when idle)
//   owner         current or last grantee (debug)
//   locked        high while a burst lock is held
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       locked
);

    localparam int OW = $clog2(NUM_REQ);
    // One extra bit so owner + offset cannot overflow before the modulo.
    localparam int IW = OW + 1;
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [7:0]      burst_cnt_reg, burst_cnt_next;

    logic            grant_vld;
    logic [OW-1:0]   grant_idx;

    // Candidate k is requester (owner + 1 + k) mod NUM_REQ, so the current
    // owner is the last candidate and a lone requester is re-granted.
    logic [OW-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IW-1:0] sum;
            assign sum           = {1'b0, owner_reg} + IW'(gi + 1);
            assign cand_idx[gi]  = (sum >= IW'(NUM_REQ)) ? OW'(sum - IW'(NUM_REQ))
                                                         : sum[OW-1:0];
            assign cand_vld[gi]  = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Grant selection. Reset and a full FIFO both suppress the grant, which
    // makes every handshake output quiet in those cycles.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = owner_reg;
        if (!rst && !fifo_full) begin
            if (state_reg == LOCK && req_valid[owner_reg]) begin
                grant_vld = 1'b1;
                grant_idx = owner_reg;
            end else begin
                // Walk from the far end so the nearest candidate wins.
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (cand_vld[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand_idx[k];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign fifo_write   = grant_vld;
    assign fifo_data_in = grant_vld ? req_data[grant_idx*WIDTH +: WIDTH] : '0;
    assign owner        = owner_reg;
    assign locked       = (state_reg == LOCK);

    // Next-state logic. A grant always coincides with an accepted beat,
    // because the granted producer's valid is already known to be high.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        if (grant_vld) begin
            if (state_reg == IDLE || grant_idx != owner_reg) begin
                owner_next     = grant_idx;
                burst_cnt_next = 8'd1;
                state_next     = (MAX_BURST > 1) ? LOCK : IDLE;
            end else begin
                burst_cnt_next = burst_cnt_reg + 8'd1;
                if (burst_cnt_reg + 8'd1 == BURST_MAX) begin
                    state_next = IDLE;
                end
            end
        end else if (state_reg == LOCK) begin
            // A full FIFO holds the lock; otherwise the owner went away and
            // nobody else was asking either.
            if (!fifo_full) begin
                state_next     = IDLE;
                burst_cnt_next = 8'd0;
            end
        end else begin
            burst_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OW'(NUM_REQ - 1);
            burst_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Three instances with MAX_BURST of 4, 2
// and 1 share the same stimulus; each scenario checks the instance whose
// burst length it targets. Expected grants and data are hand-computed.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic             fifo_full;

    logic [N-1:0]     ready4, ready2, ready1;
    logic             write4, write2, write1;
    logic [W-1:0]     data4, data2, data1;
    logic [1:0]       owner4, owner2, owner1;
    logic             locked4, locked2, locked1;

    int total_cnt;
    int bad_cnt;
    int cyc;
    int pcnt [N];

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready4), .fifo_full(fifo_full), .fifo_write(write4),
        .fifo_data_in(data4), .owner(owner4), .locked(locked4)
    );

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(2)) u_mb2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready2), .fifo_full(fifo_full), .fifo_write(write2),
        .fifo_data_in(data2), .owner(owner2), .locked(locked2)
    );

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .fifo_full(fifo_full), .fifo_write(write1),
        .fifo_data_in(data1), .owner(owner1), .locked(locked1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Producer i presents i*1000 + its own beat count.
    task automatic load_counted_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = 32'(i * 1000 + pcnt[i]);
        end
    endtask

    task automatic log_txn(input string tag, input logic [N-1:0] rdy,
                           input logic wr, input logic [W-1:0] d);
        $display("cyc %0d %s: ready=%b write=%0b data=%0d", cyc, tag, rdy, wr, d);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    logic [1:0]  exp_g2 [10];
    logic [31:0] exp_d2 [10];
    logic [1:0]  exp_g1 [4];

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        exp_g2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        exp_d2 = '{32'd0, 32'd1, 32'd1000, 32'd1001, 32'd2000, 32'd2001,
                   32'd3000, 32'd3001, 32'd2, 32'd3};
        exp_g1 = '{2'd3, 2'd0, 2'd3, 2'd0};

        // ---- reset state: outputs quiet even with every producer valid ----
        next_cycle();
        req_valid = 4'b1111;
        #2;
        log_txn("reset", ready4, write4, data4);
        check_val("rst_write", 32'(write4), 32'd0);
        check_val("rst_ready", 32'(ready4), 32'd0);
        next_cycle();
        check_val("rst_owner", 32'(owner4), 32'd3);
        check_val("rst_locked", 32'(locked4), 32'd0);

        // ---- single producer, MAX_BURST=4 ----
        do_reset();
        req_valid = 4'b0100;
        for (int n = 0; n < 10; n++) begin
            req_data = '0;
            req_data[2*W +: W] = 32'(100 + n);
            #2;
            log_txn("single", ready4, write4, data4);
            check_val("single_ready", 32'(ready4), 32'b0100);
            check_val("single_write", 32'(write4), 32'd1);
            check_val("single_data", data4, 32'(100 + n));
            next_cycle();
        end
        check_val("single_owner", 32'(owner4), 32'd2);

        // ---- full contention, MAX_BURST=2 ----
        do_reset();
        req_valid = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            load_counted_data();
            #2;
            log_txn("contend", ready2, write2, data2);
            check_val("contend_write", 32'(write2), 32'd1);
            check_val("contend_ready", 32'(ready2), 32'(4'b0001 << exp_g2[n]));
            check_val("contend_data", data2, exp_d2[n]);
            pcnt[exp_g2[n]]++;
            next_cycle();
        end

        // ---- backpressure, MAX_BURST=2: owner 1 stalls with burst_cnt=1 ----
        do_reset();
        req_valid = 4'b0010;
        load_counted_data();
        #2;
        log_txn("bp_first", ready2, write2, data2);
        check_val("bp_first_ready", 32'(ready2), 32'b0010);
        next_cycle();
        req_valid = 4'b1111;
        fifo_full = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #2;
            log_txn("bp_full", ready2, write2, data2);
            check_val("bp_full_ready", 32'(ready2), 32'd0);
            check_val("bp_full_write", 32'(write2), 32'd0);
            check_val("bp_full_locked", 32'(locked2), 32'd1);
            next_cycle();
        end
        fifo_full = 1'b0;
        #2;
        log_txn("bp_resume", ready2, write2, data2);
        check_val("bp_resume_ready", 32'(ready2), 32'b0010);
        next_cycle();
        #2;
        log_txn("bp_rotate", ready2, write2, data2);
        check_val("bp_rotate_ready", 32'(ready2), 32'b0100);
        next_cycle();

        // ---- owner drops mid-lock, MAX_BURST=4 ----
        do_reset();
        req_valid = 4'b0001;
        #2;
        check_val("drop_first_ready", 32'(ready4), 32'b0001);
        next_cycle();
        req_valid = 4'b1010;
        req_data  = '0;
        req_data[1*W +: W] = 32'd555;
        req_data[3*W +: W] = 32'd777;
        #2;
        log_txn("drop", ready4, write4, data4);
        check_val("drop_locked_before", 32'(locked4), 32'd1);
        check_val("drop_ready", 32'(ready4), 32'b0010);
        check_val("drop_write", 32'(write4), 32'd1);
        check_val("drop_data", data4, 32'd555);
        next_cycle();

        // ---- wrap-around, MAX_BURST=1: producer 2 first so 3 leads ----
        do_reset();
        req_valid = 4'b0100;
        #2;
        check_val("wrap_pre_ready", 32'(ready1), 32'b0100);
        next_cycle();
        req_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            #2;
            log_txn("wrap", ready1, write1, data1);
            check_val("wrap_ready", 32'(ready1), 32'(4'b0001 << exp_g1[n]));
            check_val("wrap_locked", 32'(locked1), 32'd0);
            next_cycle();
        end

        // ---- reset mid-burst, MAX_BURST=4 ----
        do_reset();
        req_valid = 4'b0100;
        #2;
        check_val("rmb_first_ready", 32'(ready4), 32'b0100);
        next_cycle();
        req_valid = 4'b1111;
        #2;
        check_val("rmb_locked", 32'(locked4), 32'd1);
        check_val("rmb_hold_ready", 32'(ready4), 32'b0100);
        next_cycle();
        rst = 1'b1;
        #2;
        log_txn("rmb_rst", ready4, write4, data4);
        check_val("rmb_rst_write", 32'(write4), 32'd0);
        check_val("rmb_rst_ready", 32'(ready4), 32'd0);
        next_cycle();
        rst = 1'b0;
        // A fresh burst gives producer 0 exactly four beats, then producer 1.
        for (int n = 0; n < 5; n++) begin
            #2;
            log_txn("rmb_after", ready4, write4, data4);
            check_val("rmb_after_ready", 32'(ready4), (n < 4) ? 32'b0001 : 32'b0010);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
